// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side bundle for mem_arbiter.
// The slave modport is the arbiter's view; master is the side driving requests and memory.
interface mem_arbiter_if;
  localparam int unsigned DW = 32;

  logic          if_req;
  logic [DW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;

  logic          d_req;
  logic          d_we;
  logic [DW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;

  logic          mem_ce;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_rdy;

  logic          err;
  logic          stall_o;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
    output if_rdata, if_ack, d_rdata, d_ack, mem_ce, mem_we, mem_addr, mem_wdata,
           err, stall_o
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_ce, mem_we, mem_addr, mem_wdata,
           err, stall_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one single-port memory,
// with bounded data bursts ahead of a waiting fetch and an access timeout.
module mem_arbiter #(
  parameter int unsigned MAX_DATA_RUN = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int unsigned DW    = 32;
  localparam int unsigned RUN_W = (MAX_DATA_RUN > 0) ? $clog2(MAX_DATA_RUN + 1) : 1;
  localparam int unsigned TMO_W = 8;
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_DATA_RUN);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  typedef enum logic {GNT_I, GNT_D} gnt_e;

  state_e            state_q, state_d;
  gnt_e              gnt_q, gnt_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [DW-1:0]     if_rdata_q, if_rdata_d;
  logic [DW-1:0]     d_rdata_q, d_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              err_q, err_d;
  logic              mem_ce_q, mem_ce_d;
  logic              mem_we_q, mem_we_d;
  logic [DW-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
  logic              gnt_data_c;

  // Data wins unless it has already used its full run while a fetch waits.
  assign gnt_data_c = bus.d_req && !((run_q == RUN_MAX) && bus.if_req);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    run_d       = run_q;
    tmo_d       = tmo_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
    mem_ce_d    = mem_ce_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          state_d  = ACCESS;
          tmo_d    = '0;
          mem_ce_d = 1'b1;
          if (gnt_data_c) begin
            gnt_d       = GNT_D;
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            if (!bus.if_req)
              run_d = '0;
            else if (run_q != RUN_MAX)
              run_d = run_q + RUN_W'(1);
          end else begin
            gnt_d       = GNT_I;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            run_d       = '0;
          end
        end
      end

      ACCESS: begin
        if (bus.mem_rdy || (tmo_q == TMO_LAST)) begin
          state_d     = DONE;
          err_d       = !bus.mem_rdy;
          mem_ce_d    = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          // An aborted read returns zero; stores never touch d_rdata.
          if (gnt_q == GNT_I) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.mem_rdy ? bus.mem_rdata : '0;
          end else begin
            d_ack_d = 1'b1;
            if (!mem_we_q)
              d_rdata_d = bus.mem_rdy ? bus.mem_rdata : '0;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_I;
      run_q       <= '0;
      tmo_q       <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      run_q       <= run_d;
      tmo_q       <= tmo_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.err       = err_q;
  assign bus.mem_ce    = mem_ce_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.stall_o   = (bus.if_req & ~if_ack_q) | (bus.d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model of requesters,
// arbitration policy and a delayed memory, plus directed scenarios and random traffic.
module tb_mem_arbiter;
  localparam int unsigned MAXR = 4;
  localparam int unsigned TMO  = 8;

  logic clk = 1'b0;
  logic rst;
  mem_arbiter_if bus();

  mem_arbiter #(.MAX_DATA_RUN(MAXR), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // requester state
  bit          i_pend = 1'b0, d_pend = 1'b0, d_we_v = 1'b0;
  logic [31:0] i_addr = '0, d_addr_v = '0, d_wdata_v = '0;
  int          i_rate = 0, d_rate = 0, st_rate = 0;
  // memory behaviour
  int          fix_delay = 0;
  bit          fix_data = 1'b1;
  logic [31:0] fix_rdata = '0;
  // model of the arbiter's observable contract
  int          run = 0;
  int          gap = 2;
  logic [31:0] exp_ir = '0, exp_dr = '0;
  bit          act = 1'b0, act_dat = 1'b0, act_we = 1'b0;
  logic [31:0] act_addr = '0, act_wdata = '0, act_rdata = '0;
  int          act_dly = 0, act_age = 0;
  // observed completions: 1 = data ack, 0 = fetch ack
  bit          ack_log[$];
  int          obs_err = 0;

  task automatic drive_reqs();
    bus.if_req  = i_pend;
    bus.if_addr = i_addr;
    bus.d_req   = d_pend;
    bus.d_we    = d_we_v;
    bus.d_addr  = d_addr_v;
    bus.d_wdata = d_wdata_v;
  endtask

  task automatic post_i(input logic [31:0] a);
    i_pend = 1'b1; i_addr = a;
    drive_reqs();
  endtask

  task automatic post_d(input bit we, input logic [31:0] a, input logic [31:0] wd);
    d_pend = 1'b1; d_we_v = we; d_addr_v = a; d_wdata_v = wd;
    drive_reqs();
  endtask

  function automatic int pick_delay(input bit we);
    int r;
    if (fix_delay >= 0) return fix_delay;
    r = int'($urandom_range(15));
    if (r == 0 && !we) return int'(TMO) + int'($urandom_range(2));
    return r % 4;
  endfunction

  // One clock: sample at negedge, compare with the model, then drive the next inputs.
  task automatic step();
    bit seen_i, seen_d, exp_ia, exp_da, exp_err, exp_ce;
    int lat;
    @(negedge clk);
    seen_i  = bus.if_req;
    seen_d  = bus.d_req;
    exp_ia  = 1'b0;
    exp_da  = 1'b0;
    exp_err = 1'b0;
    if (!rst) begin
      act = 1'b0; run = 0; exp_ir = '0; exp_dr = '0; gap = 2;
      check_eq("rst_mem_ce", 32'(bus.mem_ce), 32'd0);
      check_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
      check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
      check_eq("rst_mem_wdata", bus.mem_wdata, 32'd0);
      check_eq("rst_acks", 32'({bus.if_ack, bus.d_ack, bus.err}), 32'd0);
    end else if (act) begin
      act_age++;
      lat = (act_dly >= int'(TMO)) ? int'(TMO) : act_dly + 1;
      if (act_age < lat) begin
        check_eq("acc_ce", 32'(bus.mem_ce), 32'd1);
        check_eq("acc_addr", bus.mem_addr, act_addr);
        check_eq("acc_we", 32'(bus.mem_we), 32'(act_we));
        if (act_dat) check_eq("acc_wdata", bus.mem_wdata, act_wdata);
      end else begin
        exp_err = (act_dly >= int'(TMO));
        if (act_dat) begin
          exp_da = 1'b1;
          if (!act_we) exp_dr = exp_err ? 32'd0 : act_rdata;
        end else begin
          exp_ia = 1'b1;
          exp_ir = exp_err ? 32'd0 : act_rdata;
        end
        act = 1'b0;
        gap = 0;
        check_eq("done_ce", 32'(bus.mem_ce), 32'd0);
      end
      check_eq("acks", 32'({bus.if_ack, bus.d_ack, bus.err}), 32'({exp_ia, exp_da, exp_err}));
    end else begin
      gap++;
      exp_ce = (gap >= 2) && (seen_i || seen_d);
      check_eq("grant_ce", 32'(bus.mem_ce), 32'(exp_ce));
      check_eq("idle_acks", 32'({bus.if_ack, bus.d_ack, bus.err}), 32'd0);
      if (exp_ce) begin
        act     = 1'b1;
        act_age = 0;
        act_dat = seen_d && !((run == int'(MAXR)) && seen_i);
        if (act_dat && seen_i) run = (run < int'(MAXR)) ? run + 1 : run;
        else                   run = 0;
        if (act_dat) begin
          act_we = bus.d_we; act_addr = bus.d_addr; act_wdata = bus.d_wdata;
        end else begin
          act_we = 1'b0; act_addr = bus.if_addr; act_wdata = '0;
        end
        act_dly = pick_delay(act_we);
        if (act_we && act_dly >= int'(TMO)) act_dly = int'(TMO) - 1;
        check_eq("grant_addr", bus.mem_addr, act_addr);
        check_eq("grant_we", 32'(bus.mem_we), 32'(act_we));
        if (act_dat) check_eq("grant_wdata", bus.mem_wdata, act_wdata);
      end else begin
        check_eq("idle_mem", 32'(bus.mem_we) | bus.mem_addr | bus.mem_wdata, 32'd0);
      end
    end
    check_eq("if_rdata", bus.if_rdata, exp_ir);
    check_eq("d_rdata", bus.d_rdata, exp_dr);
    check_eq("stall", 32'(bus.stall_o), 32'((seen_i && !exp_ia) || (seen_d && !exp_da)));
    if (bus.d_ack === 1'b1) ack_log.push_back(1'b1);
    if (bus.if_ack === 1'b1) ack_log.push_back(1'b0);
    if (bus.err === 1'b1) obs_err++;

    if (exp_ia) i_pend = 1'b0;
    if (exp_da) d_pend = 1'b0;
    if (!i_pend && int'($urandom_range(99)) < i_rate) begin
      i_pend = 1'b1; i_addr = $urandom;
    end
    if (!d_pend && int'($urandom_range(99)) < d_rate) begin
      d_pend = 1'b1; d_we_v = int'($urandom_range(99)) < st_rate;
      d_addr_v = $urandom; d_wdata_v = $urandom;
    end
    drive_reqs();

    if (act) bus.mem_rdy = (act_age == act_dly);
    else     bus.mem_rdy = 1'($urandom_range(1));
    bus.mem_rdata = fix_data ? fix_rdata : $urandom;
    if (act && bus.mem_rdy) act_rdata = bus.mem_rdata;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int k = 0;
    while ((i_pend || d_pend || act) && k < budget) begin
      step();
      k++;
    end
    check_eq(tag, 32'(i_pend || d_pend || act), 32'd0);
    step();
    step();
  endtask

  task automatic step_until_ack(input string tag, input int budget);
    int k = 0;
    bit got = 1'b0;
    while (!got && k < budget) begin
      step();
      k++;
      got = (bus.if_ack === 1'b1) || (bus.d_ack === 1'b1);
    end
    check_eq(tag, 32'(got), 32'd1);
  endtask

  initial begin
    int n;
    int ndata;
    int e0;
    bit got_i;
    rst = 1'b0;
    drive_reqs();
    bus.mem_rdy   = 1'b0;
    bus.mem_rdata = '0;
    repeat (3) step();
    rst = 1'b1;

    // Fetch with an immediately ready memory
    fix_delay = 0; fix_data = 1'b1; fix_rdata = 32'h0050_0093;
    post_i(32'h100);
    step();
    check_eq("fetch_ce", 32'(bus.mem_ce), 32'd1);
    check_eq("fetch_addr", bus.mem_addr, 32'h100);
    step();
    check_eq("fetch_ack", 32'(bus.if_ack), 32'd1);
    check_eq("fetch_rdata", bus.if_rdata, 32'h0050_0093);
    run_until_idle("fetch_idle", 10);

    // Simultaneous fetch and load: data first
    fix_delay = 1; fix_rdata = 32'h1234_5678;
    ack_log.delete();
    post_i(32'h104);
    post_d(1'b0, 32'h2000, 32'h0);
    run_until_idle("cont_idle", 20);
    check_eq("cont_count", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() == 2) begin
      check_eq("cont_first", 32'(ack_log[0]), 32'd1);
      check_eq("cont_second", 32'(ack_log[1]), 32'd0);
    end

    // Store leaves d_rdata alone
    fix_delay = 2; fix_rdata = 32'hDEAD_BEEF;
    post_d(1'b1, 32'h40, 32'hCAFE_F00D);
    step_until_ack("store_wait", 10);
    check_eq("store_ack", 32'(bus.d_ack), 32'd1);
    check_eq("store_rdata", bus.d_rdata, 32'h1234_5678);
    run_until_idle("store_idle", 10);

    // Continuous data traffic with a fetch pending
    fix_delay = 0; d_rate = 100; st_rate = 0;
    ack_log.delete();
    post_i(32'h108);
    post_d(1'b0, 32'h3000, 32'h0);
    got_i = 1'b0;
    for (int k = 0; k < 60 && !got_i; k++) begin
      step();
      got_i = (ack_log.size() > 0) && (ack_log[$] == 1'b0);
    end
    check_eq("starve_fetch", 32'(got_i), 32'd1);
    ndata = 0;
    foreach (ack_log[j]) if (ack_log[j]) ndata++;
    check_eq("starve_runs", 32'(ndata), 32'(MAXR));
    d_rate = 0;
    run_until_idle("starve_idle", 20);

    // Memory never ready: abort after TIMEOUT cycles
    e0 = obs_err;
    fix_delay = 100;
    post_i(32'h200);
    step();
    n = (bus.mem_ce === 1'b1) ? 1 : 0;
    got_i = 1'b0;
    for (int k = 0; k < 30 && !got_i; k++) begin
      step();
      if (bus.if_ack === 1'b1) got_i = 1'b1;
      else if (bus.mem_ce === 1'b1) n++;
    end
    check_eq("tmo_ack", 32'(got_i), 32'd1);
    check_eq("tmo_cycles", 32'(n), 32'(TMO));
    check_eq("tmo_err", 32'(bus.err), 32'd1);
    check_eq("tmo_rdata", bus.if_rdata, 32'd0);
    fix_delay = 0; fix_rdata = 32'h0BAD_F00D;
    run_until_idle("tmo_idle", 10);
    post_d(1'b0, 32'h44, 32'h0);
    run_until_idle("post_tmo_idle", 10);
    check_eq("post_tmo_rdata", bus.d_rdata, 32'h0BAD_F00D);
    check_eq("tmo_err_count", 32'(obs_err - e0), 32'd1);

    // Reset during ACCESS drops the access
    fix_delay = 100;
    post_i(32'h300);
    step();
    step();
    rst = 1'b0;
    step();
    check_eq("rst_mid_ce", 32'(bus.mem_ce), 32'd0);
    check_eq("rst_mid_ack", 32'(bus.if_ack), 32'd0);
    rst = 1'b1;
    fix_delay = 0; fix_rdata = 32'h0000_7777;
    step();
    check_eq("rst_regrant_ce", 32'(bus.mem_ce), 32'd1);
    run_until_idle("rst_idle", 10);

    // Random traffic
    fix_delay = -1; fix_data = 1'b0;
    i_rate = 30; d_rate = 40; st_rate = 40;
    repeat (3000) step();
    i_rate = 0; d_rate = 0;
    run_until_idle("rand_drain", 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_DATA_RUN, default 4: consecutive data grants allowed while an instruction request waits.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum ACCESS cycles without mem_rdy before the access is aborted.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port if_req  in  1  instruction-fetch request, held until if_ack.
REQ-006 SHALL have port if_addr  in  32  fetch address, stable while if_req is high.
REQ-007 SHALL have port if_rdata  out  32  fetched word, valid while if_ack is high.
REQ-008 SHALL have port if_ack  out  1  one-cycle fetch completion pulse.
REQ-009 SHALL have port d_req  in  1  data request from the load/store stage, held until d_ack.
REQ-010 SHALL have port d_we  in  1  data request is a store (1) or a load (0).
REQ-011 SHALL have port d_addr  in  32  data address.
REQ-012 SHALL have port d_wdata  in  32  store data.
REQ-013 SHALL have port d_rdata  out  32  load data, valid while d_ack is high.
REQ-014 SHALL have port d_ack  out  1  one-cycle data completion pulse.
REQ-015 SHALL have port mem_ce  out  1  chip enable to the shared single-port memory.
REQ-016 SHALL have port mem_we  out  1  write enable to the memory.
REQ-017 SHALL have port mem_addr  out  32  memory address.
REQ-018 SHALL have port mem_wdata  out  32  memory write data.
REQ-019 SHALL have port mem_rdata  in  32  memory read data, valid when mem_rdy is high.
REQ-020 SHALL have port mem_rdy  in  1  memory completion, sampled only in ACCESS.
REQ-021 SHALL have port err  out  1  timeout flag, pulses together with the aborted access's ack.
REQ-022 SHALL have port stall_o  out  1  pipeline stall: (if_req & ~if_ack) | (d_req & ~d_ack), combinational.

Function
REQ-023 SHALL use a three-state FSM: IDLE, ACCESS, DONE.
REQ-024 IDLE, no request: SHALL stay in IDLE.
REQ-025 IDLE, any request: SHALL register the grant (GNT_I or GNT_D) and move to ACCESS.
REQ-026 Arbitration SHALL grant data when d_req is high, except when run_cnt == MAX_DATA_RUN and if_req is high; instruction is then granted.
REQ-027 run_cnt (width clog2(MAX_DATA_RUN+1)) SHALL increment on each data grant made while if_req is high, saturating at MAX_DATA_RUN.
REQ-028 run_cnt SHALL clear on an instruction grant, and on any grant made while if_req is low.
REQ-029 ACCESS SHALL drive mem_ce=1 and mem_addr from the granted port.
REQ-030 ACCESS SHALL drive mem_we=d_we and mem_wdata=d_wdata for data grants, and mem_we=0 for instruction grants.
REQ-031 All mem_* outputs SHALL be 0 outside ACCESS.
REQ-032 ACCESS SHALL hold its outputs until mem_rdy=1, then register mem_rdata into the granted port's rdata register and move to DONE.
REQ-033 tmo_cnt (8 bits) SHALL clear on entering ACCESS and increment each ACCESS cycle with mem_rdy=0.
REQ-034 When tmo_cnt reaches TIMEOUT-1 with mem_rdy=0, the FSM SHALL move to DONE with rdata forced to 32'h0 and err set.
REQ-035 DONE SHALL pulse the granted ack for exactly one cycle, pulse err if set, and return to IDLE.
REQ-036 The requester SHALL drop or renew its request at the edge ending the ack cycle; a request seen in IDLE is treated as new.
REQ-037 Minimum latency SHALL be: request seen in IDLE at cycle 0, ACCESS at cycle 1 (mem_rdy=1), ack at cycle 2; throughput is one access per 3 cycles.
REQ-038 A store ack SHALL leave d_rdata unchanged.
REQ-039 if_rdata and d_rdata SHALL hold their last values between acks.
REQ-040 A request that drops mid-ACCESS SHALL NOT abort the access; it completes and acks normally.
REQ-041 Simultaneous if_req and d_req in IDLE SHALL be resolved per REQ-026; the loser waits and is served in the next IDLE.

Reset
REQ-042 rst=0 at a rising edge SHALL force IDLE, clear run_cnt and tmo_cnt, and set if_rdata, d_rdata, if_ack, d_ack, err and all mem_* outputs to 0, including mid-ACCESS (access dropped, no ack).
REQ-043 Outputs SHALL remain at reset values while rst=0; the first grant can occur in the first cycle after rst=1.

Verification
REQ-044 Fetch: if_req=1, if_addr=0x100, mem_rdy=1 immediately, mem_rdata=0x00500093 -> mem_ce=1 at cycle 1, if_ack=1 with if_rdata=0x00500093 at cycle 2.
REQ-045 Contention: if_req and d_req (load, 0x2000) both raised in IDLE -> data granted first, d_ack before if_ack, then fetch served.
REQ-046 Starvation: d_req held continuously with if_req pending, MAX_DATA_RUN=4 -> 4 data acks, then the 5th grant goes to instruction.
REQ-047 Store: d_we=1, d_addr=0x40, d_wdata=0xCAFEF00D -> mem_we=1 and mem_wdata=0xCAFEF00D throughout ACCESS, d_rdata unchanged at ack.
REQ-048 Timeout: mem_rdy held 0, TIMEOUT=8 -> ack and err pulse together after 8 ACCESS cycles, rdata=0; the next request proceeds normally.
REQ-049 Reset mid-ACCESS: rst=0 while mem_ce=1 -> next cycle mem_ce=0, no ack, FSM in IDLE.
